mhp_rx_parser: RTL and testbench

Receive-side frame decoder for the MHP link. It pulls bytes from the Ethernet payload FIFO and parses the MHP header (dst, src, size, type). It streams out the payload, checks the 16-bit additive checksum appended by the transmit path, and discards the zero padding up to the 50-byte frame. It sits between the Ethernet RX FIFO and the node command logic, and emits exactly one ok/err verdict per frame.

---
 rtl/mhp_rx_parser.sv | 164 ++++++++++++++++
 tb/tb_mhp_rx_parser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mhp_rx_parser.sv
// rtl/mhp_rx_parser.sv - MHP receive frame decoder: header parse, payload stream, checksum verdict
module mhp_rx_parser #(
  parameter logic [15:0] MY_BCAST     = 16'hFFFF,
  parameter int          MAX_PAYLOAD  = 41,
  parameter int          IDLE_TIMEOUT = 62
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rdata,
  input  logic        i_rready,
  output logic        o_rreq,
  input  logic [15:0] i_my_addr,
  output logic [15:0] o_dst_addr,
  output logic [15:0] o_src_addr,
  output logic [15:0] o_size,
  output logic [7:0]  o_type,
  output logic        o_pvalid,
  output logic [7:0]  o_pdata,
  output logic [7:0]  o_pidx,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [2:0]  o_err_code,
  output logic        o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAP, S_WAIT, S_DRAIN} state_t;

  state_t      state, state_nx;
  logic [7:0]  idx;
  logic [15:0] acc;
  logic [7:0]  tmo;
  logic        drain;
  logic [7:0]  chk_hi;

  logic        tmo_hit;
  logic [15:0] dst_full, size_full, idx16, end_idx;
  logic        dst_bad, size_bad, is_payload, is_chk_hi, is_chk_lo, in_sum;

  assign tmo_hit   = (tmo == 8'(IDLE_TIMEOUT - 1));
  assign dst_full  = {o_dst_addr[15:8], i_rdata};
  assign size_full = {o_size[15:8], i_rdata};
  assign idx16     = {8'd0, idx};
  // First checksum byte sits at 7+size; o_size is only trustworthy once idx >= 7.
  assign end_idx   = o_size + 16'd7;

  assign dst_bad    = (idx == 8'd1) && (dst_full != i_my_addr) && (dst_full != MY_BCAST);
  assign size_bad   = (idx == 8'd5) && (size_full > 16'(MAX_PAYLOAD));
  assign is_payload = (idx >= 8'd7) && (idx16 < end_idx);
  assign is_chk_hi  = (idx >= 8'd7) && (idx16 == end_idx);
  assign is_chk_lo  = (idx >= 8'd7) && (idx16 == end_idx + 16'd1);
  assign in_sum     = (idx <= 8'd6) || is_payload;

  always_comb begin
    state_nx = state;
    o_rreq   = 1'b0;
    o_busy   = (state != S_IDLE);
    case (state)
      S_IDLE:  if (i_rready) state_nx = S_REQ;
      S_REQ: begin
        o_rreq   = 1'b1;
        state_nx = S_CAP;
      end
      S_CAP: begin
        if (drain || dst_bad || size_bad || is_chk_lo) state_nx = S_DRAIN;
        else                                            state_nx = S_WAIT;
      end
      S_WAIT, S_DRAIN: begin
        if (i_rready)     state_nx = S_REQ;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      idx         <= 8'd0;
      acc         <= 16'd0;
      tmo         <= 8'd0;
      drain       <= 1'b0;
      chk_hi      <= 8'd0;
      o_dst_addr  <= 16'd0;
      o_src_addr  <= 16'd0;
      o_size      <= 16'd0;
      o_type      <= 8'd0;
      o_pvalid    <= 1'b0;
      o_pdata     <= 8'd0;
      o_pidx      <= 8'd0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= 3'd0;
    end else begin
      state       <= state_nx;
      o_pvalid    <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          idx   <= 8'd0;
          acc   <= 16'd0;
          tmo   <= 8'd0;
          drain <= 1'b0;
        end
        S_CAP: begin
          tmo <= 8'd0;
          if (idx != 8'hFF) idx <= idx + 8'd1;
          if (!drain) begin
            case (idx)
              8'd0: o_dst_addr[15:8] <= i_rdata;
              8'd1: o_dst_addr[7:0]  <= i_rdata;
              8'd2: o_src_addr[15:8] <= i_rdata;
              8'd3: o_src_addr[7:0]  <= i_rdata;
              8'd4: o_size[15:8]     <= i_rdata;
              8'd5: o_size[7:0]      <= i_rdata;
              8'd6: o_type           <= i_rdata;
              default: ;
            endcase
            if (in_sum) acc <= acc + {8'd0, i_rdata};
            if (is_payload) begin
              o_pvalid <= 1'b1;
              o_pdata  <= i_rdata;
              o_pidx   <= idx - 8'd7;
            end
            if (is_chk_hi) chk_hi <= i_rdata;
            if (dst_bad) begin
              o_frame_err <= 1'b1;
              o_err_code  <= 3'd1;
              drain       <= 1'b1;
            end else if (size_bad) begin
              o_frame_err <= 1'b1;
              o_err_code  <= 3'd2;
              drain       <= 1'b1;
            end else if (is_chk_lo) begin
              drain <= 1'b1;
              if ({chk_hi, i_rdata} == acc) begin
                o_frame_ok <= 1'b1;
                o_err_code <= 3'd0;
              end else begin
                o_frame_err <= 1'b1;
                o_err_code  <= 3'd4;
              end
            end
          end
        end
        S_WAIT, S_DRAIN: begin
          if (i_rready) begin
            tmo <= 8'd0;
          end else if (tmo_hit) begin
            // Running dry mid-frame is truncation; a drained frame already has its verdict.
            if (state == S_WAIT) begin
              o_frame_err <= 1'b1;
              o_err_code  <= 3'd3;
            end
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mhp_rx_parser.sv
// tb/tb_mhp_rx_parser.sv - directed self-checking bench for mhp_rx_parser
module tb_mhp_rx_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rdata;
  logic        rready;
  logic        rreq;
  logic [15:0] my_addr;
  logic [15:0] dst_addr, src_addr, size;
  logic [7:0]  ftype;
  logic        pvalid;
  logic [7:0]  pdata, pidx;
  logic        frame_ok, frame_err;
  logic [2:0]  err_code;
  logic        busy;

  mhp_rx_parser dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rdata    (rdata),
    .i_rready   (rready),
    .o_rreq     (rreq),
    .i_my_addr  (my_addr),
    .o_dst_addr (dst_addr),
    .o_src_addr (src_addr),
    .o_size     (size),
    .o_type     (ftype),
    .o_pvalid   (pvalid),
    .o_pdata    (pdata),
    .o_pidx     (pidx),
    .o_frame_ok (frame_ok),
    .o_frame_err(frame_err),
    .o_err_code (err_code),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  int cyc = 0, last_pop = 0;
  int checks = 0, errors = 0;
  int n_pv, n_ok, n_err, n_both, err_cyc, fall_cyc;
  logic [7:0] last_pdata, last_pidx;
  logic [2:0] last_code;
  logic busy_prev = 1'b0;

  // FIFO model: data shows up the cycle after a pop request.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rreq && fifo.size() > 0) begin
      rdata <= fifo.pop_front();
      last_pop = cyc;
    end
  end

  always @(negedge clk) begin
    rready = (fifo.size() != 0);
    if (pvalid) begin
      n_pv++;
      last_pdata = pdata;
      last_pidx  = pidx;
    end
    if (frame_ok) n_ok++;
    if (frame_err) begin
      n_err++;
      err_cyc   = cyc;
      last_code = err_code;
    end
    if (frame_ok && frame_err) n_both++;
    if (busy_prev && !busy) fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_pv = 0; n_ok = 0; n_err = 0; n_both = 0;
    err_cyc = 0; fall_cyc = 0;
    last_pdata = 8'h00; last_pidx = 8'h00; last_code = 3'd0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) fifo.push_back(8'h00);
  endtask

  task automatic push_hdr(input logic [15:0] d, input logic [15:0] s, input logic [15:0] sz, input logic [7:0] t);
    push(d[15:8]); push(d[7:0]); push(s[15:8]); push(s[7:0]);
    push(sz[15:8]); push(sz[7:0]); push(t);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!busy && n < 40) begin @(negedge clk); n++; end
    check({tag, "_start"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_end"}, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rdata = 8'h00; rready = 1'b0; my_addr = 16'h0005;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_dst", {16'd0, dst_addr}, 32'd0);
    check("rst_size", {16'd0, size}, 32'd0);
    check("rst_ctl", {26'd0, busy, rreq, frame_ok, frame_err, pvalid, 1'b0}, 32'd0);
    check("rst_code", {29'd0, err_code}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unicast, one payload byte; 50-byte frame.
    clear_stats();
    push_hdr(16'h0005, 16'h0001, 16'h0001, 8'h83); push(8'h00); push(8'h00); push(8'h8A); pad(40);
    wait_done("uni");
    check("uni_ok", n_ok, 1);
    check("uni_err", n_err, 0);
    check("uni_pv", n_pv, 1);
    check("uni_pidx", {24'd0, last_pidx}, 32'd0);
    check("uni_pdata", {24'd0, last_pdata}, 32'd0);
    check("uni_dst", {16'd0, dst_addr}, 32'h0005);
    check("uni_src", {16'd0, src_addr}, 32'h0001);
    check("uni_size", {16'd0, size}, 32'h0001);
    check("uni_type", {24'd0, ftype}, 32'h83);
    // Last byte is captured one edge after its pop, then 62 idle cycles.
    check("uni_idle", fall_cyc - last_pop, 63);
    check("uni_drained", fifo.size(), 0);

    // Broadcast destination.
    clear_stats();
    push_hdr(16'hFFFF, 16'h0001, 16'h0001, 8'h83); push(8'h00); push(8'h02); push(8'h83); pad(40);
    wait_done("bc");
    check("bc_ok", n_ok, 1);
    check("bc_err", n_err, 0);
    check("bc_dst", {16'd0, dst_addr}, 32'hFFFF);

    // Zero-length payload: chk directly after the type byte; 5+2+0x10 = 0x17.
    clear_stats();
    push_hdr(16'h0005, 16'h0002, 16'h0000, 8'h10); push(8'h00); push(8'h17); pad(41);
    wait_done("zero");
    check("zero_ok", n_ok, 1);
    check("zero_pv", n_pv, 0);

    // Destination mismatch.
    clear_stats();
    push_hdr(16'h0007, 16'h0001, 16'h0001, 8'h83); push(8'h00); push(8'h00); push(8'h8C); pad(40);
    wait_done("dst");
    check("dst_err", n_err, 1);
    check("dst_code", {29'd0, last_code}, 32'd1);
    check("dst_ok", n_ok, 0);
    check("dst_pv", n_pv, 0);
    check("dst_drained", fifo.size(), 0);

    // Oversize length field.
    clear_stats();
    push_hdr(16'h0005, 16'h0001, 16'h002A, 8'h83); pad(43);
    wait_done("size");
    check("size_err", n_err, 1);
    check("size_code", {29'd0, last_code}, 32'd2);
    check("size_pv", n_pv, 0);

    // Checksum off by one.
    clear_stats();
    push_hdr(16'h0005, 16'h0001, 16'h0001, 8'h83); push(8'h00); push(8'h00); push(8'h8B); pad(40);
    wait_done("chk");
    check("chk_err", n_err, 1);
    check("chk_code", {29'd0, last_code}, 32'd4);
    check("chk_pv", n_pv, 1);
    check("chk_ok", n_ok, 0);

    // Truncated: FIFO runs dry after first payload byte.
    clear_stats();
    push_hdr(16'h0005, 16'h0001, 16'h0003, 8'h81); push(8'hAA);
    wait_done("trunc");
    check("trunc_err", n_err, 1);
    check("trunc_code", {29'd0, last_code}, 32'd3);
    check("trunc_time", err_cyc - last_pop, 63);
    check("trunc_pv", n_pv, 1);
    check("trunc_pdata", {24'd0, last_pdata}, 32'hAA);

    // Reset after four header bytes, then a complete valid frame.
    clear_stats();
    push_hdr(16'h0005, 16'h0001, 16'h0001, 8'h83);
    begin
      int n;
      n = 0;
      while (fifo.size() > 3 && n < 100) begin @(negedge clk); n++; end
      check("rst_mid_reach", fifo.size(), 3);
    end
    fifo.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_dst", {16'd0, dst_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    push_hdr(16'h0005, 16'h0001, 16'h0001, 8'h83); push(8'h00); push(8'h00); push(8'h8A); pad(40);
    wait_done("post");
    check("post_ok", n_ok, 1);
    check("post_err", n_err, 0);
    check("post_src", {16'd0, src_addr}, 32'h0001);
    check("both_high", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
